// File: rtl/spart_pkg.sv
// Shared SPART types and constants: receive state encoding, oversampling
// ratio, standard baud divisors (50 MHz clock) and a 2-of-3 vote helper.
package spart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  localparam int OVS_DEF = 16;

  localparam logic [15:0] DIV_4800  = 16'h028A;
  localparam logic [15:0] DIV_9600  = 16'h0145;
  localparam logic [15:0] DIV_19200 = 16'h00A2;
  localparam logic [15:0] DIV_38400 = 16'h0050;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// Baud tick generator shared by the SPART rx and tx paths: latches the
// divisor on restart and emits a one-clock tick every divisor+1 clocks.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic             restart,
  output logic             tick
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  // restart re-phases the counter so the first tick lands divisor+1 clocks later
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      cnt   <= '0;
      tick  <= 1'b0;
    end else if (restart) begin
      div_q <= divisor;
      cnt   <= divisor;
      tick  <= 1'b0;
    end else if (cnt == '0) begin
      cnt   <= div_q;
      tick  <= 1'b1;
    end else begin
      cnt   <= cnt - 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/spart_rx.sv
// SPART receive engine: 8N1 deserialiser with 16x oversampling, start-bit
// validation, break handling, framing and overrun flags. Optional 2-of-3
// majority voting per bit when SPART_RX_MAJORITY_EN is defined.
module spart_rx
  import spart_pkg::*;
#(
  parameter int OVS   = OVS_DEF,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rxd,
  input  logic [DIV_W-1:0] divisor,
  input  logic             rd_ack,
  output logic [7:0]       rx_data,
  output logic             rda,
  output logic             framing_err,
  output logic             overrun,
  output logic             busy
);

  localparam logic [3:0] T_MID = 4'(OVS / 2 - 1);
  localparam logic [3:0] T_END = 4'(OVS - 1);

  rx_state_t  state;
  logic       sync1, rxs, rxs_d;
  logic       tick, start;
  logic       start_dec, bit_dec, bit_val, frame_done;
  logic [3:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  assign start = (state == IDLE) && rxs_d && !rxs;

  spart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .divisor (divisor),
    .restart (start),
    .tick    (tick)
  );

`ifdef SPART_RX_MAJORITY_EN
  logic [1:0] vote;
  logic       armed;

  // vote holds the two previous tick samples; armed marks that the previous
  // tick was tcnt==15, so a freshly cleared tcnt==0 is not taken as a decision
  always_ff @(posedge clk) begin
    if (rst || start) begin
      vote  <= 2'b11;
      armed <= 1'b0;
    end else if (tick) begin
      vote  <= {vote[0], rxs};
      armed <= (tcnt == T_END);
    end
  end

  assign bit_val   = maj3(vote[1], vote[0], rxs);
  assign start_dec = tick && (tcnt == T_MID + 4'd1);
  assign bit_dec   = tick && armed && (tcnt == 4'd0);
`else
  assign bit_val   = rxs;
  assign start_dec = tick && (tcnt == T_MID);
  assign bit_dec   = tick && (tcnt == T_END);
`endif

  assign frame_done = (state == STOP) && bit_dec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (tick) tcnt <= tcnt + 4'd1;

      unique case (state)
        IDLE: if (start) begin
          tcnt  <= '0;
          bcnt  <= '0;
          state <= START;
          busy  <= 1'b1;
        end
        START: if (start_dec) begin
          if (!bit_val) begin
            state <= DATA;
            tcnt  <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: if (bit_dec) begin
          shreg <= {bit_val, shreg[7:1]};
          bcnt  <= bcnt + 3'd1;
          if (bcnt == 3'd7) state <= STOP;
        end
        STOP: if (bit_dec) begin
          if (bit_val) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= BREAK;
          end
        end
        BREAK: if (rxs) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // a read in the same cycle as completion frees the buffer for the new byte
      if (frame_done) begin
        if (!rda || rd_ack) begin
          rx_data     <= shreg;
          rda         <= 1'b1;
          framing_err <= !bit_val;
          if (rd_ack) overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rd_ack && rda) begin
        rda         <= 1'b0;
        framing_err <= 1'b0;
        overrun     <= 1'b0;
      end
    end
  end

endmodule
